// File: rtl/game_pkg.sv
// Shared encodings, widths and the LFSR step function for the guessing-game
// round sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GUESS  = 2'b01,
        ST_RESULT = 2'b10,
        ST_BAD    = 2'b11
    } game_state_t;

    localparam int LFSR_W  = 5;
    localparam int TRIES_W = 3;
    localparam int TIME_W  = 4;
    localparam int HOLD_W  = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;
    // Taps for x^5 + x^3 + 1: feedback is bit 4 xor bit 2.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw push button followed by a rising-edge
// detector; a held button yields a single one-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Round sequencer: draws the secret from a free-running LFSR, evaluates
// submitted guesses and runs the try, time and result-hold counters.
module guess_game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int TIME_LIMIT  = 10,
    parameter int RESULT_HOLD = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_btn,
    input  logic               submit_btn,
    input  logic [LFSR_W-1:0]  switches,
    output logic [1:0]         state,
    output logic [LFSR_W-1:0]  guess,
    output logic [LFSR_W-1:0]  rng,
    output logic               win,
    output logic               hint_high,
    output logic               hint_low,
    output logic [TRIES_W-1:0] tries_left,
    output logic [TIME_W-1:0]  time_left
);

    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(TIME_LIMIT);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(RESULT_HOLD);

    logic start_pulse;
    logic submit_pulse;

    game_state_t        state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]  rng_q, rng_d;
    logic [LFSR_W-1:0]  guess_q, guess_d;
    logic               win_q, win_d;
    logic               hint_high_q, hint_high_d;
    logic               hint_low_q, hint_low_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_btn),
        .pulse (start_pulse)
    );

    btn_sync_edge u_submit_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (submit_btn),
        .pulse (submit_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            rng_q       <= '0;
            guess_q     <= '0;
            win_q       <= 1'b0;
            hint_high_q <= 1'b0;
            hint_low_q  <= 1'b0;
            tries_q     <= '0;
            time_q      <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            rng_q       <= rng_d;
            guess_q     <= guess_d;
            win_q       <= win_d;
            hint_high_q <= hint_high_d;
            hint_low_q  <= hint_low_d;
            tries_q     <= tries_d;
            time_q      <= time_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_step(lfsr_q);
        rng_d       = rng_q;
        guess_d     = guess_q;
        win_d       = win_q;
        hint_high_d = hint_high_q;
        hint_low_d  = hint_low_q;
        tries_d     = tries_q;
        time_d      = time_q;
        hold_d      = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d     = ST_GUESS;
                    rng_d       = lfsr_q;
                    tries_d     = TRIES_INIT;
                    time_d      = TIME_INIT;
                    win_d       = 1'b0;
                    hint_high_d = 1'b0;
                    hint_low_d  = 1'b0;
                    guess_d     = '0;
                end
            end

            ST_GUESS: begin
                // Timeout is resolved first so that a submit on the same edge overrides it.
                if (tick) begin
                    time_d = (time_q != '0) ? time_q - 1'b1 : '0;
                    if (time_q <= TIME_W'(1)) begin
                        state_d = ST_RESULT;
                        win_d   = 1'b0;
                        hold_d  = HOLD_INIT;
                    end
                end
                if (submit_pulse) begin
                    guess_d = switches;
                    if (switches == rng_q) begin
                        state_d = ST_RESULT;
                        win_d   = 1'b1;
                        hold_d  = HOLD_INIT;
                    end else if (tries_q <= TRIES_W'(1)) begin
                        state_d = ST_RESULT;
                        win_d   = 1'b0;
                        tries_d = '0;
                        hold_d  = HOLD_INIT;
                    end else begin
                        tries_d     = tries_q - 1'b1;
                        hint_high_d = (switches > rng_q);
                        hint_low_d  = (switches < rng_q);
                    end
                end
            end

            ST_RESULT: begin
                if (start_pulse) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign state      = state_q;
    assign guess      = guess_q;
    assign rng        = rng_q;
    assign win        = win_q;
    assign hint_high  = hint_high_q;
    assign hint_low   = hint_low_q;
    assign tries_left = tries_q;
    assign time_left  = time_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: directed round scenarios plus
// randomized play, all compared against a rule-level game model.
module tb_guess_game_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int TIME_LIMIT  = 10;
    localparam int RESULT_HOLD = 5;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       tick       = 1'b0;
    logic       start_btn  = 1'b0;
    logic       submit_btn = 1'b0;
    logic [4:0] switches   = '0;

    logic [1:0] state;
    logic [4:0] guess;
    logic [4:0] rng;
    logic       win;
    logic       hint_high;
    logic       hint_low;
    logic [2:0] tries_left;
    logic [3:0] time_left;

    int vectors     = 0;
    int miscompares = 0;

    // Rule-level model of the game (0 idle, 1 guessing, 2 showing result).
    int m_state, m_guess, m_rng, m_tries, m_time, m_hold, m_n;
    bit m_win, m_hh, m_hl;
    bit st_h1, st_h2, st_h3, sb_h1, sb_h2, sb_h3;
    bit lfsr_bits [0:35];

    typedef struct {
        logic [4:0] sw;
        int         exp_state;
        int         exp_tries;
        int         exp_win;
        bit         chk_hints;
        bit         exp_hh;
        bit         exp_hl;
    } miss_vec_t;

    miss_vec_t miss_tbl [3];

    always #5 clk = ~clk;

    guess_game_ctrl #(
        .MAX_TRIES   (MAX_TRIES),
        .TIME_LIMIT  (TIME_LIMIT),
        .RESULT_HOLD (RESULT_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_btn  (start_btn),
        .submit_btn (submit_btn),
        .switches   (switches),
        .state      (state),
        .guess      (guess),
        .rng        (rng),
        .win        (win),
        .hint_high  (hint_high),
        .hint_low   (hint_low),
        .tries_left (tries_left),
        .time_left  (time_left)
    );

    // Register value n edges after reset, read as a 5-bit window of the LFSR bit stream.
    function automatic int lfsr_at(input int n);
        int idx = n % 31;
        int v   = 0;
        for (int j = 0; j < 5; j++) v = v * 2 + int'(lfsr_bits[idx + j]);
        return v;
    endfunction

    task automatic model_edge();
        bit sp, up, done, last_tick;
        int now_lfsr;
        done = 1'b0;
        if (rst) begin
            m_state = 0; m_guess = 0; m_rng = 0; m_tries = 0; m_time = 0; m_hold = 0; m_n = 0;
            m_win = 0; m_hh = 0; m_hl = 0;
            st_h1 = 0; st_h2 = 0; st_h3 = 0; sb_h1 = 0; sb_h2 = 0; sb_h3 = 0;
            return;
        end
        sp = st_h2 & ~st_h3;
        up = sb_h2 & ~sb_h3;
        st_h3 = st_h2; st_h2 = st_h1; st_h1 = start_btn;
        sb_h3 = sb_h2; sb_h2 = sb_h1; sb_h1 = submit_btn;
        now_lfsr = lfsr_at(m_n);
        m_n++;
        case (m_state)
            0: if (sp) begin
                m_state = 1; m_rng = now_lfsr; m_tries = MAX_TRIES; m_time = TIME_LIMIT;
                m_win = 0; m_hh = 0; m_hl = 0; m_guess = 0;
            end
            1: begin
                if (up) begin
                    m_guess = int'(switches);
                    if (int'(switches) == m_rng) begin
                        m_state = 2; m_win = 1; m_hold = RESULT_HOLD; done = 1;
                    end else if (m_tries == 1) begin
                        m_state = 2; m_win = 0; m_tries = 0; m_hold = RESULT_HOLD; done = 1;
                    end else begin
                        m_tries = m_tries - 1;
                        m_hh = (int'(switches) > m_rng);
                        m_hl = (int'(switches) < m_rng);
                    end
                end
                if (tick) begin
                    last_tick = (m_time == 1);
                    if (m_time > 0) m_time = m_time - 1;
                    if (last_tick && !done) begin
                        m_state = 2; m_win = 0; m_hold = RESULT_HOLD;
                    end
                end
            end
            default: begin
                if (sp) m_state = 0;
                else if (tick) begin
                    if (m_hold > 0) m_hold = m_hold - 1;
                    if (m_hold == 0) m_state = 0;
                end
            end
        endcase
    endtask

    task automatic check_output(input string name);
        logic [21:0] act, exp;
        act = {state, guess, rng, win, hint_high, hint_low, tries_left, time_left};
        exp = {2'(m_state), 5'(m_guess), 5'(m_rng), m_win, m_hh, m_hl, 3'(m_tries), 4'(m_time)};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got st=%0d g=%0d rng=%0d win=%0d hh=%0d hl=%0d tries=%0d time=%0d, need st=%0d g=%0d rng=%0d win=%0d hh=%0d hl=%0d tries=%0d time=%0d",
                     name, state, guess, rng, win, hint_high, hint_low, tries_left, time_left,
                     m_state, m_guess, m_rng, m_win, m_hh, m_hl, m_tries, m_time);
        end
    endtask

    task automatic check_field(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, need %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, advances the model on the edge and checks at the falling edge.
    task automatic apply_stimulus(input bit r, input bit s, input bit u, input bit t,
                                  input logic [4:0] sw, input string name);
        rst = r; start_btn = s; submit_btn = u; tick = t; switches = sw;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_output(name);
    endtask

    task automatic press(input bit s, input bit u, input bit t3, input logic [4:0] sw, input string name);
        apply_stimulus(1'b0, s, u, 1'b0, sw, name);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, sw, name);
        apply_stimulus(1'b0, 1'b0, 1'b0, t3, sw, name);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run did not complete within time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  exp_rng;
        bit  found;
        logic [4:0] sw;

        lfsr_bits[0] = 0; lfsr_bits[1] = 0; lfsr_bits[2] = 0; lfsr_bits[3] = 0; lfsr_bits[4] = 1;
        for (int m = 5; m < 36; m++) lfsr_bits[m] = lfsr_bits[m - 5] ^ lfsr_bits[m - 3];

        miss_tbl[0] = '{5'd25, 1, 2, 0, 1'b1, 1'b1, 1'b0};
        miss_tbl[1] = '{5'd3,  1, 1, 0, 1'b1, 1'b0, 1'b1};
        miss_tbl[2] = '{5'd7,  2, 0, 0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        apply_stimulus(1, 0, 0, 0, 5'd0, "reset");
        apply_stimulus(1, 0, 0, 0, 5'd0, "reset");
        check_field("rst_state", state, 0);
        check_field("rst_rng", rng, 0);
        check_field("rst_tries", tries_left, 0);
        check_field("rst_time", time_left, 0);
        check_field("rst_flags", {win, hint_high, hint_low}, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 5'd0, "idle");

        // Start held for 20 cycles: one round, entered on the third edge.
        exp_rng = lfsr_at(m_n + 2);
        apply_stimulus(0, 1, 0, 0, 5'd0, "start_k");
        check_field("start_k_state", state, 0);
        apply_stimulus(0, 1, 0, 0, 5'd0, "start_k1");
        check_field("start_k1_state", state, 0);
        apply_stimulus(0, 1, 0, 0, 5'd0, "start_k2");
        check_field("start_state", state, 1);
        check_field("start_tries", tries_left, 3);
        check_field("start_time", time_left, 10);
        check_field("start_rng", rng, exp_rng);
        for (int i = 0; i < 17; i++) apply_stimulus(0, 1, 0, 0, 5'd0, "start_hold");
        check_field("start_once_state", state, 1);
        apply_stimulus(0, 0, 0, 0, 5'd0, "idle");

        // Correct guess, then the result is held for RESULT_HOLD ticks.
        sw = 5'(exp_rng);
        press(0, 1, 0, sw, "win");
        check_field("win_state", state, 2);
        check_field("win_flag", win, 1);
        check_field("win_guess", guess, exp_rng);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(0, 0, 0, 1, sw, "win_hold");
            if (i == 4) check_field("win_hold4_state", state, 2);
            if (i < 5) apply_stimulus(0, 0, 0, 0, sw, "win_hold");
        end
        check_field("win_exit_state", state, 0);

        // Wait until the secret will be 20, then play the three-miss table.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (lfsr_at(m_n + 2) == 20) found = 1'b1;
            else apply_stimulus(0, 0, 0, 0, 5'd0, "seek20");
        end
        check_field("seek20_found", found, 1);
        press(1, 0, 0, 5'd0, "miss_start");
        check_field("miss_rng", rng, 20);
        for (int i = 0; i < 3; i++) begin
            press(0, 1, 0, miss_tbl[i].sw, "miss");
            check_field($sformatf("miss%0d_state", i), state, miss_tbl[i].exp_state);
            check_field($sformatf("miss%0d_tries", i), tries_left, miss_tbl[i].exp_tries);
            check_field($sformatf("miss%0d_win", i), win, miss_tbl[i].exp_win);
            if (miss_tbl[i].chk_hints) begin
                check_field($sformatf("miss%0d_hh", i), hint_high, miss_tbl[i].exp_hh);
                check_field($sformatf("miss%0d_hl", i), hint_low, miss_tbl[i].exp_hl);
            end
        end

        // Early exit from RESULT, then a fresh round.
        press(1, 0, 0, 5'd0, "early_exit");
        check_field("early_exit_state", state, 0);
        exp_rng = lfsr_at(m_n + 2);
        press(1, 0, 0, 5'd0, "restart");
        check_field("restart_state", state, 1);
        check_field("restart_rng", rng, exp_rng);

        // Timeout after TIME_LIMIT ticks.
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(0, 0, 0, 1, 5'd0, "timeout");
            if (i == 9) begin
                check_field("timeout9_state", state, 1);
                check_field("timeout9_time", time_left, 1);
            end
        end
        check_field("timeout_state", state, 2);
        check_field("timeout_win", win, 0);
        check_field("timeout_time", time_left, 0);

        // Correct guess landing on the last tick wins.
        press(1, 0, 0, 5'd0, "exit");
        exp_rng = lfsr_at(m_n + 2);
        press(1, 0, 0, 5'd0, "lasttick_start");
        for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 0, 1, 5'(exp_rng), "lasttick_ticks");
        press(0, 1, 1, 5'(exp_rng), "lasttick_submit");
        check_field("lasttick_state", state, 2);
        check_field("lasttick_win", win, 1);

        // Reset in the middle of a round, then IDLE ignores ticks and submits.
        press(1, 0, 0, 5'd0, "exit2");
        exp_rng = lfsr_at(m_n + 2);
        press(1, 0, 0, 5'd0, "midrst_start");
        press(0, 1, 0, 5'(exp_rng) ^ 5'd1, "midrst_miss");
        check_field("midrst_tries_before", tries_left, 2);
        apply_stimulus(1, 0, 0, 0, 5'd0, "midrst");
        check_field("midrst_state", state, 0);
        check_field("midrst_guess", guess, 0);
        check_field("midrst_rng", rng, 0);
        check_field("midrst_counts", {tries_left, time_left}, 0);
        check_field("midrst_flags", {win, hint_high, hint_low}, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, (i % 2) == 0, 1, 5'd9, "idle_ignore");
        apply_stimulus(0, 0, 0, 0, 5'd9, "idle_ignore");
        apply_stimulus(0, 0, 0, 0, 5'd9, "idle_ignore");
        check_field("idle_ignore_state", state, 0);
        check_field("idle_ignore_guess", guess, 0);
        check_field("idle_ignore_counts", {tries_left, time_left}, 0);

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rsw;
            rsw = ($urandom_range(0, 1) == 1) ? 5'(m_rng) : 5'($urandom_range(0, 31));
            apply_stimulus($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
                           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, rsw, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/guess_game_ctrl.md
# guess_game_ctrl

Round sequencer for the number-guessing game. Owns the 2-bit game `state`, draws the secret number from a free-running LFSR, and latches the player's switch guess on a submit press. Counts remaining tries and a per-round timeout, and returns to idle after the result has been shown. Its `state`, `guess` and `rng` outputs drive the result/hex display and LED scroller logic directly.

## Interface
Parameters:
- `MAX_TRIES`, default 3: guesses allowed per round, range 1–7.
- `TIME_LIMIT`, default 10: `tick` pulses allowed per round, range 1–15.
- `RESULT_HOLD`, default 5: `tick` pulses the result is shown before the block returns to idle, range 1–15.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: one-cycle clock-enable pulse (about 1 Hz) from the divider. Already synchronous to `clk`.
- `start_btn`, in, 1: raw push button, asynchronous, active-high.
- `submit_btn`, in, 1: raw push button, asynchronous, active-high.
- `switches`, in, 5: player guess, read when a submit press is accepted.
- `state`, out, 2: 00 IDLE, 01 GUESS, 10 RESULT. 11 is never driven.
- `guess`, out, 5: last accepted guess.
- `rng`, out, 5: secret number for the current round.
- `win`, out, 1: valid in RESULT. 1 = correct guess, 0 = loss.
- `hint_high`, out, 1: last wrong guess was above `rng`.
- `hint_low`, out, 1: last wrong guess was below `rng`.
- `tries_left`, out, 3: guesses remaining in the round.
- `time_left`, out, 4: ticks remaining in the round.

## Operation
- **LFSR**
  - 5-bit maximal Fibonacci LFSR, x^5+x^3+1.
  - Advances every `clk` cycle in all states.
  - Reset seed is 5'b00001. The LFSR is never zero, so `rng` is in 1..31.
- **Button path**
  - Each button goes through a 2-flop synchronizer plus a previous-value flop.
  - A press is the one-cycle pulse `sync & ~prev`.
  - Holding a button generates exactly one pulse.
- **IDLE**
  - Start pulse → GUESS.
  - On the same edge: `rng` ← LFSR, `tries_left` ← MAX_TRIES, `time_left` ← TIME_LIMIT; `win`, `hint_high`, `hint_low` and `guess` cleared.
  - Submit pulses and ticks are ignored.
- **GUESS**, priority order:
  1. Submit pulse: `guess` ← `switches`.
     - If `switches` == `rng` → RESULT, `win`=1.
     - Else if `tries_left` == 1 → RESULT, `win`=0, `tries_left`=0.
     - Else `tries_left` decrements, and `hint_high`/`hint_low` are set by magnitude (exactly one high).
  2. Tick: `time_left` decrements.
     - If `time_left` was 1 → RESULT, `win`=0.
     - A submit in the same cycle that already moved the block to RESULT takes precedence, so a correct last-tick guess wins.
  3. Start pulse is ignored.
- **RESULT**
  - Entry loads a hold counter with RESULT_HOLD.
  - Each tick decrements the hold counter. At expiry → IDLE.
  - A start pulse → IDLE immediately.
  - `guess`, `rng`, `win` and the hints hold their values.
- **Illegal state** 11 → IDLE on the next edge.
- **Reset** at any point, mid-round included:
  - `state`=00.
  - `guess`, `rng`, `tries_left`, `time_left` and the hold counter = 0.
  - `win`, `hint_high`, `hint_low` = 0.
  - Synchronizer flops = 0. LFSR = 00001.

## Timing
- A button first sampled high at edge k gives its pulse in the cycle after edge k+1. The state and outputs update at edge k+2, which is 3 edges total.
- `tick` acts on the same edge it is sampled high. `time_left` updates 1 cycle after the tick.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Width rules: the 5-bit compare is unsigned. Counters saturate at 0 and never wrap.

## Structure
- `game_pkg` holds the state encodings (`ST_IDLE`, `ST_GUESS`, `ST_RESULT`), the LFSR width, taps and seed, and the counter widths.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse. Instanced twice, once per button.

## Test plan
- **Start:** reset, then start held 20 cycles → `state`=01 exactly 3 edges after the first sampled high, one round only. `tries_left`=3, `time_left`=10, `rng` = LFSR value at that edge.
- **Win:** in GUESS, `switches`=`rng`, submit → `state`=10, `win`=1, `guess`=`rng`. After 5 ticks → `state`=00.
- **Three misses:** `rng`=20; submit 25, then 3, then 7.
  - After 25: `hint_high`=1, `tries_left`=2.
  - After 3: `hint_low`=1, `tries_left`=1.
  - After 7: `state`=10, `win`=0, `tries_left`=0.
- **Timeout:** 10 ticks with no submit → `state`=10, `win`=0, `time_left`=0. A correct submit landing on the same cycle as the 10th tick → `win`=1.
- **Reset mid-round:** `rst` asserted in GUESS with `tries_left`=2 → next edge `state`=00 and all outputs 0. Ticks and submits in IDLE leave everything unchanged.
- **Early exit from RESULT:** start press in RESULT before the hold expires → `state`=00. A second start press → new round with a new `rng` drawn from the LFSR.
